mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-port memory bus arbiter between instruction fetch and load/store
// Grants one master at a time, drains flushed fetches and aborts stalled slaves after TIMEOUT cycles.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [3:0]        lsu_be_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_ack_o,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_be_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              hold_flag_o,
  output logic              bus_err_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, BUSY_I_DROP} state_t;

  state_t            r_state, w_state_nxt;
  logic [SW-1:0]     r_starve_cnt, w_starve_nxt;
  logic [TW-1:0]     r_tmo_cnt;
  logic              r_bus_req, r_bus_we;
  logic [3:0]        r_bus_be;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;

  logic w_busy, w_timeout, w_done, w_if_ok, w_grant_if, w_grant_lsu;

  assign w_busy    = (r_state != IDLE);
  assign w_timeout = w_busy & ~bus_ack_i & (r_tmo_cnt == TW'(TIMEOUT - 1));
  assign w_done    = w_busy & (bus_ack_i | w_timeout);
  assign w_if_ok   = if_req_i & ~flush_i;

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_grant_if   = 1'b0;
    w_grant_lsu  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_if_ok && (!lsu_req_i || r_starve_cnt == SW'(STARVE_MAX))) begin
          w_grant_if   = 1'b1;
          w_starve_nxt = '0;
          w_state_nxt  = BUSY_I;
        end else if (lsu_req_i) begin
          w_grant_lsu = 1'b1;
          w_state_nxt = BUSY_D;
          // Counts contested LSU wins even when a flush kept IF out this cycle.
          if (if_req_i && r_starve_cnt != SW'(STARVE_MAX))
            w_starve_nxt = r_starve_cnt + SW'(1);
        end
      end
      BUSY_D: if (w_done) w_state_nxt = IDLE;
      BUSY_I: begin
        if (w_done)       w_state_nxt = IDLE;
        else if (flush_i) w_state_nxt = BUSY_I_DROP;
      end
      BUSY_I_DROP: if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_be     <= 4'h0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_grant_lsu) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= lsu_we_i;
        r_bus_be    <= lsu_be_i;
        r_bus_addr  <= lsu_addr_i;
        r_bus_wdata <= lsu_wdata_i;
        r_tmo_cnt   <= '0;
      end else if (w_grant_if) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= 1'b0;
        r_bus_be    <= 4'hF;
        r_bus_addr  <= if_addr_i;
        r_bus_wdata <= '0;
        r_tmo_cnt   <= '0;
      end else if (w_done) begin
        r_bus_req <= 1'b0;
      end else if (w_busy) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
    end
  end

  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_be_o    = r_bus_be;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;

  // A flushed fetch still completes on the bus but is never acknowledged upstream.
  assign if_ack_o    = (r_state == BUSY_I) & w_done;
  assign if_rdata_o  = (r_state == BUSY_I && bus_ack_i) ? bus_rdata_i : '0;
  assign lsu_ack_o   = (r_state == BUSY_D) & w_done;
  assign lsu_rdata_o = (r_state == BUSY_D && bus_ack_i) ? bus_rdata_i : '0;
  assign bus_err_o   = w_timeout;
  assign hold_flag_o = rstn & lsu_req_i & ~lsu_ack_o;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized scoreboard bench for mem_bus_arbiter
// A transaction-level model predicts grants, acks and per-cycle flags; a monitor compares them.
module tb_mem_bus_arbiter;
  localparam int SM  = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req_i, lsu_req_i, lsu_we_i, flush_i, bus_ack_i;
  logic [31:0] if_addr_i, lsu_addr_i, lsu_wdata_i, bus_rdata_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] if_rdata_o, lsu_rdata_o, bus_addr_o, bus_wdata_o;
  logic        if_ack_o, lsu_ack_o, bus_req_o, bus_we_o, hold_flag_o, bus_err_o;
  logic [3:0]  bus_be_o;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_rdata_o(lsu_rdata_o), .lsu_ack_o(lsu_ack_o),
    .flush_i(flush_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .hold_flag_o(hold_flag_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
  typedef struct { int cyc; logic if_ack; logic [31:0] if_rdata; logic lsu_ack;
                   logic [31:0] lsu_rdata; logic err; } rsp_t;
  typedef struct { int cyc; logic hold; logic breq; } cyc_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  cyc_t cyc_q[$];

  int checks = 0, failures = 0, cyc = 0;
  bit run_model = 0;
  int owner = 0;  // 0 none, 1 LSU, 2 IF
  bit dropped = 0;
  int starve = 0, age = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    rsp_t r;
    cyc_t c;
    cmd_t k;
    bit tmo, grant;
    r.cyc = cyc; r.if_ack = 0; r.if_rdata = 0; r.lsu_ack = 0; r.lsu_rdata = 0; r.err = 0;
    c.cyc = cyc;
    c.breq = (owner != 0);
    grant = 0;
    if (owner != 0) begin
      tmo = !bus_ack_i && (age == TMO - 1);
      if (bus_ack_i || tmo) begin
        r.err = tmo;
        if (owner == 1) begin
          r.lsu_ack = 1; r.lsu_rdata = bus_ack_i ? bus_rdata_i : 32'h0;
        end else if (!dropped) begin
          r.if_ack = 1; r.if_rdata = bus_ack_i ? bus_rdata_i : 32'h0;
        end
        if (r.err || r.lsu_ack || r.if_ack) rsp_q.push_back(r);
        owner = 0;
      end else begin
        age++;
        if (owner == 2 && flush_i) dropped = 1;
      end
    end else if (if_req_i && !flush_i && (!lsu_req_i || starve == SM)) begin
      owner = 2; starve = 0; grant = 1;
      k.we = 0; k.be = 4'hF; k.addr = if_addr_i; k.wdata = 0;
    end else if (lsu_req_i) begin
      owner = 1; grant = 1;
      if (if_req_i && starve < SM) starve++;
      k.we = lsu_we_i; k.be = lsu_be_i; k.addr = lsu_addr_i; k.wdata = lsu_wdata_i;
    end
    if (grant) begin
      age = 0; dropped = 0;
      cmd_q.push_back(k);
    end
    c.hold = lsu_req_i && !r.lsu_ack;
    cyc_q.push_back(c);
  endtask

  // Monitor: compares DUT outputs against queued expectations.
  initial begin
    logic prev_breq = 0;
    cmd_t k;
    rsp_t r;
    bit any;
    forever begin
      @(negedge clk);
      #2;
      if (run_model) begin
        if (bus_req_o && !prev_breq) begin
          if (cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
          else begin
            k = cmd_q.pop_front();
            chk("bus_cmd", {bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o},
                {k.we, k.be, k.addr, k.wdata});
          end
        end
        any = if_ack_o || lsu_ack_o || bus_err_o;
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
          r = rsp_q.pop_front();
          chk("rsp", {if_ack_o, if_rdata_o, lsu_ack_o, lsu_rdata_o, bus_err_o},
              {r.if_ack, r.if_rdata, r.lsu_ack, r.lsu_rdata, r.err});
        end else if (any) begin
          chk("rsp_unexpected", {if_ack_o, lsu_ack_o, bus_err_o}, 0);
        end
        if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
          chk("hold_breq", {hold_flag_o, bus_req_o}, {cyc_q[0].hold, cyc_q[0].breq});
          void'(cyc_q.pop_front());
        end
      end
      prev_breq = bus_req_o;
    end
  end

  initial begin
    bit last_if_ack = 0, last_lsu_ack = 0, last_flush = 0, dead = 0;
    bit seen;
    rstn = 0; if_req_i = 0; lsu_req_i = 0; lsu_we_i = 0; flush_i = 0; bus_ack_i = 0;
    if_addr_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; bus_rdata_i = 0; lsu_be_i = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, if_ack_o, lsu_ack_o,
                       bus_err_o, hold_flag_o, if_rdata_o, lsu_rdata_o}, 0);
    @(negedge clk);
    rstn = 1;

    // Randomized traffic, then drain.
    for (int i = 0; i < 3030; i++) begin
      @(negedge clk);
      cyc++;
      run_model = 1;
      if (i < 3000) begin
        if (!if_req_i || last_if_ack || last_flush) begin
          if_req_i = ($urandom % 3) != 0; if_addr_i = $urandom & 32'hFFFF_FFFC;
        end
        if (!lsu_req_i || last_lsu_ack) begin
          lsu_req_i = $urandom % 2; lsu_we_i = $urandom % 2; lsu_be_i = 4'($urandom);
          lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
        end
        flush_i = ($urandom % 12) == 0;
        if (i % 200 == 0) dead = ($urandom % 3) == 0;
        bus_ack_i = bus_req_o ? (!dead && ($urandom % 3) == 0) : (($urandom % 6) == 0);
      end else begin
        if_req_i = 0; lsu_req_i = 0; flush_i = 0;
        bus_ack_i = bus_req_o;
      end
      bus_rdata_i = $urandom;
      last_flush = flush_i;
      #1;
      model_step();
      last_if_ack = if_ack_o;
      last_lsu_ack = lsu_ack_o;
    end
    @(negedge clk);
    cyc++;
    run_model = 0;
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);

    // Reset asserted in the middle of a store.
    bus_ack_i = 0; if_req_i = 0; lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'h3;
    lsu_addr_i = 32'h200; lsu_wdata_i = 32'h1234_5678;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = bus_req_o;
    end
    chk("rst_setup_breq", seen, 1);
    #3;
    rstn = 0;
    #1;
    chk("rst_async_outs", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, if_ack_o,
                           lsu_ack_o, bus_err_o, hold_flag_o, lsu_rdata_o}, 0);
    lsu_req_i = 0;
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_ack_i = 1; bus_rdata_i = $urandom;
      #1;
      chk("post_rst_idle", {bus_req_o, lsu_ack_o, if_ack_o, bus_err_o}, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
